// File: rtl/pending_encoder16x4.sv
// pending_encoder16x4: sticky 16-line pending register drained as a 4-bit index stream over valid/ready.
// Optional ENC_ROUND_ROBIN_EN selects rotating priority instead of fixed lowest-index priority.
module pending_encoder16x4 #(
  parameter int N_IN   = 16,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_IN-1:0]   input1,
  output logic [CODE_W-1:0] output1,
  output logic              valid,
  input  logic              ready,
  output logic [CODE_W:0]   pend_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  logic [N_IN-1:0] pending, pending_n, moved;
  logic [CODE_W-1:0] sel;
  logic [CODE_W:0] cnt_n;
  logic load;
`ifdef ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] ptr, k;
  // scan offsets high to low so the smallest offset from ptr wins
  always_comb begin
    sel = '0;
    k = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      k = ptr + CODE_W'(i);
      if (pending[k]) sel = k;
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (load) ptr <= sel + 1'b1;
`else
  always_comb begin
    sel = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (pending[i]) sel = CODE_W'(i);
  end
`endif
  always_comb begin
    load = |pending && (state == EMPTY || ready);
    state_n = (load || (state == FULL && !ready)) ? FULL : EMPTY;
    moved = load ? (N_IN'(1) << sel) : '0;
    pending_n = (pending & ~moved) | ({N_IN{en}} & input1);
    cnt_n = '0;
    for (int i = 0; i < N_IN; i++)
      cnt_n = cnt_n + (CODE_W + 1)'(pending_n[i]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= EMPTY;
      pending  <= '0;
      output1  <= '0;
      pend_cnt <= '0;
    end else begin
      state    <= state_n;
      pending  <= pending_n;
      pend_cnt <= cnt_n;
      if (load) output1 <= sel;
    end
  assign valid = (state == FULL);
endmodule

// File: tb/tb_pending_encoder16x4.sv
// tb_pending_encoder16x4: directed self-checking bench for pending_encoder16x4.
module tb_pending_encoder16x4;
  logic clk = 1'b0;
  logic rst, en, ready, valid;
  logic [15:0] input1;
  logic [3:0] output1;
  logic [4:0] pend_cnt;
  int errors = 0;
  int checks = 0;

  pending_encoder16x4 dut (
    .clk(clk), .rst(rst), .en(en), .input1(input1),
    .output1(output1), .valid(valid), .ready(ready), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; input1 = '0;
    step(); step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0d exp=0", valid); end
    checks++; if (output1 !== 4'd0) begin errors++; $display("FAIL reset_output1 got=%0d exp=0", output1); end
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", pend_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    en = 1'b1; ready = 1'b1; input1 = 16'h0020;
    step();
    input1 = '0;
    checks++; if (pend_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt_k got=%0d exp=1", pend_cnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_k got=%0d exp=0", valid); end
    step();
    checks++; if (valid !== 1'b1 || output1 !== 4'd5) begin errors++; $display("FAIL single_issue got=%0d/%0d exp=1/5", valid, output1); end
    checks++; if (pend_cnt !== 5'd0) begin errors++; $display("FAIL single_cnt_k1 got=%0d exp=0", pend_cnt); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%0d exp=0", valid); end
  endtask

  task automatic test_multi();
    logic [3:0] exp_idx [4];
    exp_idx = '{4'd0, 4'd5, 4'd10, 4'd15};
    rst = 1'b1; step(); rst = 1'b0;
    input1 = 16'h8421;
    step();
    input1 = '0;
    checks++; if (pend_cnt !== 5'd4) begin errors++; $display("FAIL multi_cnt0 got=%0d exp=4", pend_cnt); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (valid !== 1'b1 || output1 !== exp_idx[i]) begin errors++; $display("FAIL multi_idx%0d got=%0d/%0d exp=1/%0d", i, valid, output1, exp_idx[i]); end
      checks++; if (pend_cnt !== 5'(3 - i)) begin errors++; $display("FAIL multi_cnt%0d got=%0d exp=%0d", i, pend_cnt, 3 - i); end
    end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL multi_end got=%0d exp=0", valid); end
  endtask

  task automatic test_backpressure();
    ready = 1'b0; input1 = 16'h0006;
    step();
    input1 = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (valid !== 1'b1 || output1 !== 4'd1 || pend_cnt !== 5'd1) begin errors++; $display("FAIL bp_hold%0d got=%0d/%0d/%0d exp=1/1/1", i, valid, output1, pend_cnt); end
    end
    ready = 1'b1;
    step();
    checks++; if (valid !== 1'b1 || output1 !== 4'd2 || pend_cnt !== 5'd0) begin errors++; $display("FAIL bp_next got=%0d/%0d/%0d exp=1/2/0", valid, output1, pend_cnt); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_end got=%0d exp=0", valid); end
  endtask

  task automatic test_set_wins();
    input1 = 16'h0008;
    step();
    step();
    input1 = '0;
    checks++; if (valid !== 1'b1 || output1 !== 4'd3 || pend_cnt !== 5'd1) begin errors++; $display("FAIL sw_load got=%0d/%0d/%0d exp=1/3/1", valid, output1, pend_cnt); end
    step();
    checks++; if (valid !== 1'b1 || output1 !== 4'd3 || pend_cnt !== 5'd0) begin errors++; $display("FAIL sw_again got=%0d/%0d/%0d exp=1/3/0", valid, output1, pend_cnt); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sw_end got=%0d exp=0", valid); end
    en = 1'b0; input1 = 16'hFFFF;
    step();
    checks++; if (pend_cnt !== 5'd0 || valid !== 1'b0) begin errors++; $display("FAIL en_off1 got=%0d/%0d exp=0/0", pend_cnt, valid); end
    step();
    checks++; if (pend_cnt !== 5'd0 || valid !== 1'b0) begin errors++; $display("FAIL en_off2 got=%0d/%0d exp=0/0", pend_cnt, valid); end
    en = 1'b1; input1 = '0;
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; input1 = 16'h001F;
    step();
    input1 = '0;
    step();
    checks++; if (valid !== 1'b1 || pend_cnt !== 5'd4) begin errors++; $display("FAIL mid_pre got=%0d/%0d exp=1/4", valid, pend_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (valid !== 1'b0 || pend_cnt !== 5'd0 || output1 !== 4'd0) begin errors++; $display("FAIL mid_rst got=%0d/%0d/%0d exp=0/0/0", valid, pend_cnt, output1); end
    step();
    checks++; if (valid !== 1'b0 || pend_cnt !== 5'd0) begin errors++; $display("FAIL mid_after got=%0d/%0d exp=0/0", valid, pend_cnt); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      input1 = 16'h0003;
      step();
      input1 = '0;
      step();
      checks++; if (valid !== 1'b1 || output1 !== 4'd0 || pend_cnt !== 5'd1) begin errors++; $display("FAIL b2b%0d_first got=%0d/%0d/%0d exp=1/0/1", r, valid, output1, pend_cnt); end
      step();
      checks++; if (valid !== 1'b1 || output1 !== 4'd1 || pend_cnt !== 5'd0) begin errors++; $display("FAIL b2b%0d_second got=%0d/%0d/%0d exp=1/1/0", r, valid, output1, pend_cnt); end
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b%0d_end got=%0d exp=0", r, valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_set_wins();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
